// File: rtl/data_delay_buf.sv
// First-word-fall-through buffer that absorbs a non-stallable delay-line stream, dropping words on overflow.
// Optional saturating drop counter on o_drop_cnt when DATA_DELAY_BUF_DROP_CNT_EN is defined.
module data_delay_buf #(
  parameter int unsigned DWIDTH   = 8,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned AFULL_TH = 3
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [DWIDTH-1:0]            i_data,
  input  logic                         i_valid,
  output logic                         o_ready,
  output logic [DWIDTH-1:0]            o_data,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic                         o_afull,
`ifdef DATA_DELAY_BUF_DROP_CNT_EN
  output logic [15:0]                  o_drop_cnt,
`endif
  output logic                         o_drop
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [CW-1:0]     remain_c;
  logic [DWIDTH-1:0] data_q, data_d;
  logic              valid_q, ready_q, afull_q, drop_q;
  logic              full_c, pop_c, push_c, drop_c;

  // Handshake decode and next-state for pointers, occupancy and head register
  always_comb begin
    full_c   = (count_q == CW'(DEPTH));
    pop_c    = valid_q & i_ready;
    push_c   = i_valid & (~full_c | pop_c);
    drop_c   = i_valid & full_c & ~pop_c;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    data_d   = data_q;

    if (push_c) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_c)  rd_ptr_d = rd_ptr_q + AW'(1);

    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Words still stored once this cycle's pop is taken; decides where the next head comes from
    remain_c = count_q - CW'(pop_c);
    if (push_c && (remain_c == CW'(0))) begin
      data_d = i_data;
    end else if (pop_c && (remain_c != CW'(0))) begin
      data_d = mem_q[rd_ptr_d];
    end
  end

  // Storage array, intentionally left without reset
  always_ff @(posedge i_clk) begin
    if (push_c) mem_q[wr_ptr_q] <= i_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      ready_q  <= 1'b1;
      afull_q  <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      data_q   <= data_d;
      valid_q  <= (count_d != CW'(0));
      ready_q  <= (count_d != CW'(DEPTH));
      afull_q  <= (count_d >= CW'(AFULL_TH));
      drop_q   <= drop_c;
    end
  end

`ifdef DATA_DELAY_BUF_DROP_CNT_EN
  logic [15:0] drop_cnt_q;

  // Saturating count of discarded words
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      drop_cnt_q <= '0;
    end else if (drop_c && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign o_drop_cnt = drop_cnt_q;
`endif

  assign o_data  = data_q;
  assign o_valid = valid_q;
  assign o_ready = ready_q;
  assign o_count = count_q;
  assign o_afull = afull_q;
  assign o_drop  = drop_q;

endmodule

// File: tb/tb_data_delay_buf.sv
// Scoreboard bench for data_delay_buf: stimulus pushes expected words, a negedge monitor pops and compares.
module tb_data_delay_buf;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AFT   = 3;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] i_data;
  logic          i_valid;
  logic          i_ready;
  logic          o_ready;
  logic [DW-1:0] o_data;
  logic          o_valid;
  logic [2:0]    o_count;
  logic          o_afull;
  logic          o_drop;
`ifdef DATA_DELAY_BUF_DROP_CNT_EN
  logic [15:0]   o_drop_cnt;
`endif

  int errors = 0;
  int checks = 0;
  int mcount = 0;
  int mdrops = 0;
  logic [DW-1:0] exp_q [$];

  data_delay_buf #(.DWIDTH(DW), .DEPTH(DEPTH), .AFULL_TH(AFT)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_data     (i_data),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_count    (o_count),
    .o_afull    (o_afull),
`ifdef DATA_DELAY_BUF_DROP_CNT_EN
    .o_drop_cnt (o_drop_cnt),
`endif
    .o_drop     (o_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: head data must match the oldest expected word; consume it on a handshake
  always @(negedge clk) begin
    if (rst_n && o_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        chk("o_data", int'(o_data), int'(exp_q[0]));
        if (i_ready) void'(exp_q.pop_front());
      end
    end
  end

  // One clock of stimulus plus model update and status checks
  task automatic drive(input logic v, input logic [DW-1:0] d, input logic r);
    bit pop, push, drop;
    i_valid = v;
    i_data  = d;
    i_ready = r;
    @(posedge clk);
    pop  = (mcount > 0) && r;
    push = v && ((mcount < int'(DEPTH)) || pop);
    drop = v && !push;
    if (push) exp_q.push_back(d);
    mcount = mcount + int'(push) - int'(pop);
    if (drop) mdrops++;
    #1;
    chk("o_count", int'(o_count), mcount);
    chk("o_valid", int'(o_valid), int'(mcount > 0));
    chk("o_ready", int'(o_ready), int'(mcount < int'(DEPTH)));
    chk("o_afull", int'(o_afull), int'(mcount >= int'(AFT)));
    chk("o_drop", int'(o_drop), int'(drop));
`ifdef DATA_DELAY_BUF_DROP_CNT_EN
    chk("o_drop_cnt", int'(o_drop_cnt), mdrops);
`endif
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_valid"}, int'(o_valid), 0);
    chk({tag, "_data"},  int'(o_data),  0);
    chk({tag, "_count"}, int'(o_count), 0);
    chk({tag, "_ready"}, int'(o_ready), 1);
    chk({tag, "_afull"}, int'(o_afull), 0);
    chk({tag, "_drop"},  int'(o_drop),  0);
`ifdef DATA_DELAY_BUF_DROP_CNT_EN
    chk({tag, "_drop_cnt"}, int'(o_drop_cnt), 0);
`endif
  endtask

  initial begin
    rst_n   = 1'b0;
    i_valid = 1'b0;
    i_data  = '0;
    i_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_values("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Single word round trip
    drive(1'b1, 8'h11, 1'b1);
    chk("first_data", int'(o_data), 'h11);
    drive(1'b0, 8'h00, 1'b1);
    drive(1'b0, 8'h00, 1'b1);

    // Fill with downstream stalled, then drain in order
    for (int i = 1; i <= 4; i++) drive(1'b1, 8'(i), 1'b0);
    repeat (5) drive(1'b0, 8'h00, 1'b1);

    // Overflow drop, then simultaneous push and pop while full
    for (int i = 0; i < 4; i++) drive(1'b1, 8'(8'h21 + i), 1'b0);
    drive(1'b1, 8'h05, 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    drive(1'b1, 8'hAA, 1'b1);
    repeat (5) drive(1'b0, 8'h00, 1'b1);

    // Continuous stream with toggling ready, wraps pointers
    for (int i = 0; i < 8; i++) drive(1'b1, 8'(8'h30 + i), 1'(i % 2));
    repeat (6) drive(1'b0, 8'h00, 1'b1);

    // Reset with three words stored
    for (int i = 0; i < 3; i++) drive(1'b1, 8'(8'h41 + i), 1'b0);
    i_valid = 1'b0;
    rst_n   = 1'b0;
    #1;
    exp_q.delete();
    mcount = 0;
    mdrops = 0;
    chk_reset_values("midrst");
    #3;
    rst_n = 1'b1;
    drive(1'b0, 8'h00, 1'b1);
    drive(1'b1, 8'h7E, 1'b0);
    chk("post_rst_data", int'(o_data), 'h7E);
    repeat (3) drive(1'b0, 8'h00, 1'b1);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
